cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Common-data-bus arbiter for the Tomasulo core. Accepts completed results from the add, multiply and branch functional units, holds each in a one-entry slot, and broadcasts one result per cycle on the CDB to the reservation stations and ROB. Arbitration is oldest-first by ROB age relative to the ROB head pointer. A flush input discards all pending results on misprediction.

## Interface
Parameters:
- NREQ, 3, number of functional-unit requesters (0 = add, 1 = mul, 2 = branch)
- DATA_W, 16, result width
- TAG_W, 3, ROB tag width (ROB depth 2^TAG_W = 8)

Ports:
- clk1  in  1  single clock; all state on posedge
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  NREQ  result valid per unit
- in_tag  in  NREQ*TAG_W  ROB tag per unit
- in_data  in  NREQ*DATA_W  result value per unit
- in_ready  out  NREQ  slot can accept this cycle
- rob_head  in  TAG_W  current ROB head pointer
- flush  in  1  discard all pending results
- cdb_valid  out  1  broadcast valid
- cdb_tag  out  TAG_W  broadcast ROB tag
- cdb_data  out  DATA_W  broadcast value
- cdb_src  out  2  index of winning unit

## Operation
- Slot i is loaded at the edge where in_valid[i] & in_ready[i]. The unit must hold tag/data stable until accepted.
- in_ready[i] = !flush & (!slot_valid[i] | win[i]). A slot that wins may be refilled at the same edge.
- Age of slot i = (slot_tag[i] - rob_head) mod 2^TAG_W. It is computed at TAG_W width and wraps naturally.
- Winner: the valid slot with the smallest age. Equal ages (duplicate tags, illegal) resolve to the lowest index. A simulation assertion fires on duplicate valid tags.
- At each edge with any slot valid and !flush:
  - the winner's tag, data and index are registered onto the cdb_* outputs;
  - cdb_valid is set to 1;
  - the winner's slot clears unless it is refilled at the same edge.
- At an edge with no valid slot: cdb_valid = 0. cdb_tag, cdb_data and cdb_src hold their last values.
- At an edge with flush = 1: all slots clear, cdb_valid = 0, and inputs are not accepted.
- rob_head may change any cycle. Arbitration uses the current-cycle value.

## Timing
- Reset values: cdb_valid = 0, cdb_tag = 0, cdb_data = 0, cdb_src = 0, all slots empty. in_ready follows its combinational equation, so it is all-ones after reset while flush = 0.
- Latency: a result accepted at edge E appears on the CDB after edge E+1 at the earliest.
- Throughput: one broadcast per cycle total.
- A losing slot keeps in_ready = 0 until it wins, which back-pressures its unit.
- Reset asserted mid-operation: state clears immediately (asynchronous). Pending results are lost.
- Flush and in_valid in the same cycle: the input is dropped, since in_ready = 0.

## Configuration
- CDB_PERF_CNT_EN defined:
  - adds output perf_bcast_cnt (NREQ*16): per-unit broadcast counters;
  - adds output perf_conflict_cnt (16): counts cycles where at least 2 slots are valid;
  - all counters saturate at 16'hFFFF and clear only on reset.
- CDB_PERF_CNT_EN undefined: these ports and counters are absent. Arbitration behaviour is identical either way.

## Structure
- Package tomasulo_pkg holds:
  - TAG_W and ROB_DEPTH;
  - source IDs SRC_ADD = 0, SRC_MUL = 1, SRC_BCH = 2;
  - a typedef cdb_pkt_t {valid, tag, data, src}.
- Sub-module cdb_slot, instantiated NREQ times. It is the one-entry holding register with load, clear and flush. Age comparison and output registers stay in cdb_arbiter.

## Test plan
- Single result: add valid, tag 2, data 16'h0005, rob_head 0 → in_ready[0] = 1; cdb_valid = 1 with tag 2, data 5, src 0 one edge after acceptance; cdb_valid = 0 the following cycle.
- Oldest-first across wrap: rob_head 6; mul tag 7 and branch tag 1 accepted at the same edge → mul (age 1) broadcasts first, branch (age 3) next cycle; branch in_ready = 0 for one cycle.
- Back-to-back refill: add supplies tags 3, 4, 5 every cycle with no competitors → broadcasts on 3 consecutive cycles; in_ready[0] stays 1 throughout.
- Flush: slots hold tags 4 and 5; flush = 1 for one cycle → cdb_valid = 0 next cycle; in_ready = 0 during flush; nothing from tags 4 or 5 is ever broadcast.
- Async reset mid-broadcast: drop rst_n between edges while cdb_valid = 1 → cdb_valid = 0 immediately; slots empty after release.
- With CDB_PERF_CNT_EN: 3 simultaneous results → perf_conflict_cnt = 2 and each perf_bcast_cnt entry = 1 after drain.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared Tomasulo core definitions: ROB tag geometry, CDB source IDs and the broadcast packet.
package tomasulo_pkg;

    localparam int TAG_W     = 3;
    localparam int ROB_DEPTH = 1 << TAG_W;
    localparam int DATA_W    = 16;
    localparam int SRC_W     = 2;

    typedef enum logic [SRC_W-1:0] {
        SRC_ADD = 2'd0,
        SRC_MUL = 2'd1,
        SRC_BCH = 2'd2
    } cdb_src_e;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        cdb_src_e          src;
    } cdb_pkt_t;

    // Distance of a tag from the ROB head, modulo the ROB depth; smaller means older.
    function automatic logic [TAG_W-1:0] rob_age(input logic [TAG_W-1:0] tag,
                                                 input logic [TAG_W-1:0] head);
        logic [TAG_W:0] diff;
        diff = {1'b0, tag} + ROB_DEPTH[TAG_W:0] - {1'b0, head};
        return diff[TAG_W-1:0];
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Functional-unit result handshake and CDB broadcast bundle for the CDB arbiter.
interface cdb_arbiter_if #(
    parameter int NREQ   = 3,
    parameter int DATA_W = tomasulo_pkg::DATA_W,
    parameter int TAG_W  = tomasulo_pkg::TAG_W
);

    logic [NREQ-1:0]        in_valid;
    logic [NREQ*TAG_W-1:0]  in_tag;
    logic [NREQ*DATA_W-1:0] in_data;
    logic [NREQ-1:0]        in_ready;
    logic [TAG_W-1:0]       rob_head;
    logic                   flush;
    logic                   cdb_valid;
    logic [TAG_W-1:0]       cdb_tag;
    logic [DATA_W-1:0]      cdb_data;
    logic [1:0]             cdb_src;

    // The core side: functional units, ROB head and flush control, CDB listeners.
    modport master (
        output in_valid, in_tag, in_data, rob_head, flush,
        input  in_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
    );

    modport slave (
        input  in_valid, in_tag, in_data, rob_head, flush,
        output in_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
    );

endinterface

// File: rtl/cdb_arbiter_slot.sv
// One-entry holding register for a single functional unit's completed result.
module cdb_slot #(
    parameter int DATA_W = 16,
    parameter int TAG_W  = 3
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic              flush,
    input  logic [TAG_W-1:0]  load_tag,
    input  logic [DATA_W-1:0] load_data,
    output logic              valid,
    output logic [TAG_W-1:0]  tag,
    output logic [DATA_W-1:0] data
);

    // Flush beats everything; a load beats a clear so a winning slot can be refilled in place.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            tag   <= load_tag;
            data  <= load_data;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: per-unit result slots, oldest-first selection by ROB age, registered broadcast.
// Define CDB_PERF_CNT_EN to add saturating per-unit broadcast and conflict counters.
module cdb_arbiter #(
    parameter int NREQ   = 3,
    parameter int DATA_W = tomasulo_pkg::DATA_W,
    parameter int TAG_W  = tomasulo_pkg::TAG_W
) (
    input  logic                clk1,
    input  logic                rst_n,
    cdb_arbiter_if.slave        bus
`ifdef CDB_PERF_CNT_EN
    ,
    output logic [NREQ*16-1:0]  perf_bcast_cnt,
    output logic [15:0]         perf_conflict_cnt
`endif
);

    import tomasulo_pkg::*;

    logic [NREQ-1:0]   slot_valid;
    logic [TAG_W-1:0]  slot_tag  [NREQ];
    logic [DATA_W-1:0] slot_data [NREQ];
    logic [NREQ-1:0]   win;
    logic [NREQ-1:0]   load;
    logic              any_valid;
    logic [1:0]        win_idx;
    logic [TAG_W-1:0]  win_tag;
    logic [DATA_W-1:0] win_data;
    logic [TAG_W-1:0]  best_age;
    logic              dup_tag;
    cdb_pkt_t          cdb_q;

    for (genvar g = 0; g < NREQ; g++) begin : g_slot
        cdb_slot #(
            .DATA_W (DATA_W),
            .TAG_W  (TAG_W)
        ) u_slot (
            .clk1      (clk1),
            .rst_n     (rst_n),
            .load      (load[g]),
            .clear     (win[g]),
            .flush     (bus.flush),
            .load_tag  (bus.in_tag[g*TAG_W +: TAG_W]),
            .load_data (bus.in_data[g*DATA_W +: DATA_W]),
            .valid     (slot_valid[g]),
            .tag       (slot_tag[g]),
            .data      (slot_data[g])
        );
    end

    // Scan in index order with a strict compare so equal ages fall to the lowest index.
    always_comb begin
        any_valid = 1'b0;
        win_idx   = '0;
        win_tag   = '0;
        win_data  = '0;
        best_age  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (slot_valid[i] && (!any_valid || rob_age(slot_tag[i], bus.rob_head) < best_age)) begin
                any_valid = 1'b1;
                win_idx   = 2'(i);
                win_tag   = slot_tag[i];
                win_data  = slot_data[i];
                best_age  = rob_age(slot_tag[i], bus.rob_head);
            end
        end
    end

    always_comb begin
        win = '0;
        for (int i = 0; i < NREQ; i++) begin
            win[i] = any_valid && !bus.flush && (win_idx == 2'(i));
        end
    end

    assign bus.in_ready = ~{NREQ{bus.flush}} & (~slot_valid | win);
    assign load         = bus.in_valid & bus.in_ready;

    // Tag, data and source hold their last values whenever nothing is broadcast.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            cdb_q <= '0;
        end else if (bus.flush || !any_valid) begin
            cdb_q.valid <= 1'b0;
        end else begin
            cdb_q.valid <= 1'b1;
            cdb_q.tag   <= win_tag;
            cdb_q.data  <= win_data;
            cdb_q.src   <= cdb_src_e'(win_idx);
        end
    end

    assign bus.cdb_valid = cdb_q.valid;
    assign bus.cdb_tag   = cdb_q.tag;
    assign bus.cdb_data  = cdb_q.data;
    assign bus.cdb_src   = cdb_q.src;

    always_comb begin
        dup_tag = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            for (int j = i + 1; j < NREQ; j++) begin
                if (slot_valid[i] && slot_valid[j] && slot_tag[i] == slot_tag[j]) begin
                    dup_tag = 1'b1;
                end
            end
        end
    end

    // The ROB never hands out a tag twice, so two live slots sharing one means an upstream bug.
    a_unique_tags: assert property (@(posedge clk1) disable iff (!rst_n) !dup_tag);

`ifdef CDB_PERF_CNT_EN
    logic [15:0] bcast_cnt [NREQ];
    logic [15:0] conflict_cnt;
    logic        multi_valid;

    always_comb begin
        int n;
        n = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (slot_valid[i]) begin
                n++;
            end
        end
        multi_valid = (n >= 2);
    end

    // Counters saturate rather than wrap and only reset clears them.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
            for (int i = 0; i < NREQ; i++) begin
                bcast_cnt[i] <= '0;
            end
        end else begin
            if (multi_valid && conflict_cnt != 16'hFFFF) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (win[i] && bcast_cnt[i] != 16'hFFFF) begin
                    bcast_cnt[i] <= bcast_cnt[i] + 16'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_perf
        assign perf_bcast_cnt[g*16 +: 16] = bcast_cnt[g];
    end
    assign perf_conflict_cnt = conflict_cnt;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_cdb_arbiter;

    import tomasulo_pkg::*;

    localparam int NREQ = 3;
    localparam int DW   = 16;
    localparam int TW   = 3;

    logic clk1  = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    cdb_arbiter_if #(.NREQ(NREQ), .DATA_W(DW), .TAG_W(TW)) bus ();

`ifdef CDB_PERF_CNT_EN
    logic [NREQ*16-1:0] perf_bcast_cnt;
    logic [15:0]        perf_conflict_cnt;
`endif

    cdb_arbiter #(.NREQ(NREQ), .DATA_W(DW), .TAG_W(TW)) dut (
        .clk1  (clk1),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef CDB_PERF_CNT_EN
        ,
        .perf_bcast_cnt    (perf_bcast_cnt),
        .perf_conflict_cnt (perf_conflict_cnt)
`endif
    );

    always #5 clk1 = ~clk1;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input int unit, input logic v, input logic [TW-1:0] t, input logic [DW-1:0] d);
        bus.in_valid[unit]          = v;
        bus.in_tag[unit*TW +: TW]   = t;
        bus.in_data[unit*DW +: DW]  = d;
    endtask

    task automatic clearInputs();
        bus.in_valid = '0;
        bus.in_tag   = '0;
        bus.in_data  = '0;
        bus.flush    = 1'b0;
        bus.rob_head = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clearInputs();
        #12;
        checks++;
        if ({bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.cdb_src} !== 22'd0) begin
            errors++;
            $display("[TB] FAIL reset_cdb: got %h, expected 0",
                     {bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.cdb_src});
        end
        @(negedge clk1);
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 3'b111) begin
            errors++;
            $display("[TB] FAIL reset_ready: got %b, expected 111", bus.in_ready);
        end
    endtask

    task automatic test_single_result();
        @(negedge clk1);
        bus.rob_head = 3'd0;
        applyStimulus(0, 1'b1, 3'd2, 16'h0005);
        #1;
        checks++;
        if (bus.in_ready[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_ready: got %b, expected 1", bus.in_ready[0]);
        end
        @(negedge clk1);
        applyStimulus(0, 1'b0, 3'd0, 16'h0000);
        checks++;
        if (bus.cdb_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_latency: cdb_valid got %b, expected 0", bus.cdb_valid);
        end
        @(negedge clk1);
        checks++;
        if ({bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.cdb_src} !== {1'b1, 3'd2, 16'h0005, SRC_ADD}) begin
            errors++;
            $display("[TB] FAIL single_bcast: got v=%b tag=%0d data=%h src=%0d, expected v=1 tag=2 data=0005 src=0",
                     bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.cdb_src);
        end
        @(negedge clk1);
        checks++;
        if (bus.cdb_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_idle: cdb_valid got %b, expected 0", bus.cdb_valid);
        end
    endtask

    task automatic test_oldest_first_wrap();
        @(negedge clk1);
        bus.rob_head = 3'd6;
        applyStimulus(1, 1'b1, 3'd7, 16'h0111);
        applyStimulus(2, 1'b1, 3'd1, 16'h0222);
        #1;
        checks++;
        if (bus.in_ready !== 3'b111) begin
            errors++;
            $display("[TB] FAIL wrap_accept: in_ready got %b, expected 111", bus.in_ready);
        end
        @(negedge clk1);
        applyStimulus(1, 1'b0, 3'd0, 16'h0000);
        applyStimulus(2, 1'b0, 3'd0, 16'h0000);
        #1;
        checks++;
        if (bus.in_ready !== 3'b011) begin
            errors++;
            $display("[TB] FAIL wrap_backpressure: in_ready got %b, expected 011", bus.in_ready);
        end
        @(negedge clk1);
        checks++;
        if ({bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.cdb_src} !== {1'b1, 3'd7, 16'h0111, SRC_MUL}) begin
            errors++;
            $display("[TB] FAIL wrap_first: got v=%b tag=%0d data=%h src=%0d, expected v=1 tag=7 data=0111 src=1",
                     bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.cdb_src);
        end
        @(negedge clk1);
        checks++;
        if ({bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.cdb_src} !== {1'b1, 3'd1, 16'h0222, SRC_BCH}) begin
            errors++;
            $display("[TB] FAIL wrap_second: got v=%b tag=%0d data=%h src=%0d, expected v=1 tag=1 data=0222 src=2",
                     bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.cdb_src);
        end
        @(negedge clk1);
        checks++;
        if (bus.cdb_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wrap_idle: cdb_valid got %b, expected 0", bus.cdb_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [TW-1:0] et;
        logic [DW-1:0] ed;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk1);
            bus.rob_head = 3'd3;
            if (k >= 2 && k <= 4) begin
                et = 3'(k + 1);
                ed = 16'(32'hA000 + k - 2);
                checks++;
                if ({bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.cdb_src} !== {1'b1, et, ed, SRC_ADD}) begin
                    errors++;
                    $display("[TB] FAIL b2b_bcast: step %0d got v=%b tag=%0d data=%h, expected v=1 tag=%0d data=%h",
                             k, bus.cdb_valid, bus.cdb_tag, bus.cdb_data, et, ed);
                end
            end
            if (k == 5) begin
                checks++;
                if (bus.cdb_valid !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL b2b_idle: cdb_valid got %b, expected 0", bus.cdb_valid);
                end
            end
            if (k < 3) begin
                applyStimulus(0, 1'b1, 3'(3 + k), 16'(32'hA000 + k));
                #1;
                checks++;
                if (bus.in_ready[0] !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL b2b_ready: step %0d got %b, expected 1", k, bus.in_ready[0]);
                end
            end else begin
                applyStimulus(0, 1'b0, 3'd0, 16'h0000);
            end
        end
    endtask

    task automatic test_flush();
        @(negedge clk1);
        bus.rob_head = 3'd0;
        applyStimulus(0, 1'b1, 3'd4, 16'h4444);
        applyStimulus(1, 1'b1, 3'd5, 16'h5555);
        @(negedge clk1);
        applyStimulus(0, 1'b0, 3'd0, 16'h0000);
        applyStimulus(1, 1'b0, 3'd0, 16'h0000);
        applyStimulus(2, 1'b1, 3'd6, 16'h6666);
        bus.flush = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 3'b000) begin
            errors++;
            $display("[TB] FAIL flush_ready: in_ready got %b, expected 000", bus.in_ready);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk1);
            bus.flush = 1'b0;
            applyStimulus(2, 1'b0, 3'd0, 16'h0000);
            checks++;
            if (bus.cdb_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL flush_no_bcast: cycle %0d cdb_valid got %b tag=%0d, expected 0",
                         k, bus.cdb_valid, bus.cdb_tag);
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk1);
        bus.rob_head = 3'd0;
        applyStimulus(0, 1'b1, 3'd1, 16'h1111);
        applyStimulus(1, 1'b1, 3'd2, 16'h2222);
        @(negedge clk1);
        applyStimulus(0, 1'b0, 3'd0, 16'h0000);
        applyStimulus(1, 1'b0, 3'd0, 16'h0000);
        @(negedge clk1);
        checks++;
        if ({bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.cdb_src} !== {1'b1, 3'd1, 16'h1111, SRC_ADD}) begin
            errors++;
            $display("[TB] FAIL areset_pre: got v=%b tag=%0d data=%h, expected v=1 tag=1 data=1111",
                     bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.cdb_src} !== 22'd0) begin
            errors++;
            $display("[TB] FAIL areset_immediate: got %h, expected 0",
                     {bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.cdb_src});
        end
        @(negedge clk1);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk1);
            checks++;
            if (bus.cdb_valid !== 1'b0 || bus.in_ready !== 3'b111) begin
                errors++;
                $display("[TB] FAIL areset_slots_empty: cycle %0d cdb_valid=%b in_ready=%b, expected 0 and 111",
                         k, bus.cdb_valid, bus.in_ready);
            end
        end
    endtask

    // Reference: every unit owns one slot; each cycle the slot whose tag is fewest steps past rob_head
    // is broadcast, and a unit may hand over a result when its slot is empty or being broadcast.
    task automatic test_random();
        bit            sv [NREQ];
        logic [TW-1:0] st [NREQ];
        logic [DW-1:0] sd [NREQ];
        bit            ov [NREQ];
        logic [TW-1:0] ot [NREQ];
        logic [DW-1:0] od [NREQ];
        logic          mcv;
        logic [TW-1:0] mct;
        logic [DW-1:0] mcd;
        logic [1:0]    mcs;
        logic [NREQ-1:0] exp_ready;
        logic [TW-1:0] head;
        logic [TW-1:0] cand;
        logic          fl;
        bit            clash;
        int            best, best_age, age, start;
        mcv = 1'b0; mct = '0; mcd = '0; mcs = '0;
        for (int u = 0; u < NREQ; u++) begin
            sv[u] = 1'b0; ov[u] = 1'b0; st[u] = '0; sd[u] = '0; ot[u] = '0; od[u] = '0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk1);
            checks++;
            if ({bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.cdb_src} !== {mcv, mct, mcd, mcs}) begin
                errors++;
                $display("[TB] FAIL random_cdb: cycle %0d got v=%b tag=%0d data=%h src=%0d, expected v=%b tag=%0d data=%h src=%0d",
                         cyc, bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.cdb_src, mcv, mct, mcd, mcs);
            end
            fl   = ($urandom_range(0, 9) == 0);
            head = 3'($urandom_range(0, ROB_DEPTH - 1));
            for (int u = 0; u < NREQ; u++) begin
                if (!ov[u] && $urandom_range(0, 2) != 0) begin
                    start = $urandom_range(0, ROB_DEPTH - 1);
                    cand  = '0;
                    for (int k = 0; k < ROB_DEPTH; k++) begin
                        cand  = 3'((start + k) % ROB_DEPTH);
                        clash = 1'b0;
                        for (int j = 0; j < NREQ; j++) begin
                            if ((sv[j] && st[j] == cand) || (ov[j] && ot[j] == cand)) clash = 1'b1;
                        end
                        if (!clash) break;
                    end
                    ov[u] = 1'b1;
                    ot[u] = cand;
                    od[u] = 16'($urandom);
                end
            end
            bus.flush    = fl;
            bus.rob_head = head;
            for (int u = 0; u < NREQ; u++) applyStimulus(u, ov[u], ot[u], od[u]);
            #1;
            best = -1;
            best_age = ROB_DEPTH;
            for (int u = 0; u < NREQ; u++) begin
                if (sv[u]) begin
                    age = (int'(st[u]) - int'(head) + ROB_DEPTH) % ROB_DEPTH;
                    if (age < best_age) begin
                        best = u;
                        best_age = age;
                    end
                end
            end
            for (int u = 0; u < NREQ; u++) exp_ready[u] = !fl && (!sv[u] || best == u);
            checks++;
            if (bus.in_ready !== exp_ready) begin
                errors++;
                $display("[TB] FAIL random_ready: cycle %0d got %b, expected %b", cyc, bus.in_ready, exp_ready);
            end
            if (fl) begin
                mcv = 1'b0;
                for (int u = 0; u < NREQ; u++) begin
                    sv[u] = 1'b0;
                    ov[u] = 1'b0;
                end
            end else begin
                if (best >= 0) begin
                    mcv = 1'b1;
                    mct = st[best];
                    mcd = sd[best];
                    mcs = 2'(best);
                    sv[best] = 1'b0;
                end else begin
                    mcv = 1'b0;
                end
                for (int u = 0; u < NREQ; u++) begin
                    if (ov[u] && exp_ready[u]) begin
                        sv[u] = 1'b1;
                        st[u] = ot[u];
                        sd[u] = od[u];
                        ov[u] = 1'b0;
                    end
                end
            end
        end
        @(negedge clk1);
        clearInputs();
        repeat (5) @(negedge clk1);
    endtask

`ifdef CDB_PERF_CNT_EN
    task automatic test_perf();
        @(negedge clk1);
        rst_n = 1'b0;
        clearInputs();
        @(negedge clk1);
        rst_n = 1'b1;
        checks++;
        if (perf_conflict_cnt !== 16'd0 || perf_bcast_cnt !== '0) begin
            errors++;
            $display("[TB] FAIL perf_reset: conflict=%0d bcast=%h, expected 0", perf_conflict_cnt, perf_bcast_cnt);
        end
        @(negedge clk1);
        for (int u = 0; u < NREQ; u++) applyStimulus(u, 1'b1, 3'(u), 16'(u + 1));
        @(negedge clk1);
        for (int u = 0; u < NREQ; u++) applyStimulus(u, 1'b0, 3'd0, 16'h0000);
        repeat (4) @(negedge clk1);
        checks++;
        if (perf_conflict_cnt !== 16'd2) begin
            errors++;
            $display("[TB] FAIL perf_conflict: got %0d, expected 2", perf_conflict_cnt);
        end
        for (int u = 0; u < NREQ; u++) begin
            checks++;
            if (perf_bcast_cnt[u*16 +: 16] !== 16'd1) begin
                errors++;
                $display("[TB] FAIL perf_bcast: unit %0d got %0d, expected 1", u, perf_bcast_cnt[u*16 +: 16]);
            end
        end
    endtask
`endif

    initial begin
        clearInputs();
        test_reset();
        test_single_result();
        test_oldest_first_wrap();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
`ifdef CDB_PERF_CNT_EN
        test_perf();
`else
        $display("[TB] performance counters not built; skipping test_perf");
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
